// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I datapath with a shared memory.
// It sequences each instruction, times out stalled memory accesses and halts on SYSTEM or illegal opcodes.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR/old_pc and bump PC on mem_ready
// DECODE | latch opcode, pick the execute path or halt
// EXEC   | ALU operation; branches and jumps finish here
// MEM    | data access at ALU address; loads go to WB, stores finish
// WB     | register-file write of ALU result or load data
// HALT   | sticky stop with cause flags; only rst exits
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] ALUop,
  output logic [1:0] ALUsrcA,
  output logic       ALUsrcB,
  output logic       regWrite,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [4:0] OP_LOAD   = 5'd0;
  localparam logic [4:0] OP_IMM    = 5'd4;
  localparam logic [4:0] OP_AUIPC  = 5'd5;
  localparam logic [4:0] OP_STORE  = 5'd8;
  localparam logic [4:0] OP_OP     = 5'd12;
  localparam logic [4:0] OP_LUI    = 5'd13;
  localparam logic [4:0] OP_BRANCH = 5'd24;
  localparam logic [4:0] OP_JALR   = 5'd25;
  localparam logic [4:0] OP_JAL    = 5'd27;
  localparam logic [4:0] OP_SYSTEM = 5'd28;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_n;
  logic [4:0] op_q;
  logic [7:0] cnt, cnt_n;
  logic       illegal_q, bus_err_q;
  logic       set_illegal, set_bus_err;
  logic       req, timeout;

  assign req     = (state == FETCH) || (state == MEM);
  assign timeout = req && !mem_ready && (cnt == TO_LAST);

  always_comb begin
    state_n     = state;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    IorD        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    ALUop       = 2'b00;
    ALUsrcA     = 2'b00;
    ALUsrcB     = 1'b0;
    regWrite    = 1'b0;
    wb_sel      = 2'b00;
    halted      = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;

    // ALU operand selection stays stable from EXEC through MEM/WB
    if (state == EXEC || state == MEM || state == WB) begin
      case (op_q)
        OP_LOAD, OP_STORE, OP_JALR: ALUsrcB = 1'b1;
        OP_OP:     ALUop = 2'b10;
        OP_IMM:    begin ALUsrcB = 1'b1; ALUop = 2'b11; end
        OP_LUI:    begin ALUsrcB = 1'b1; ALUsrcA = 2'b10; end
        OP_AUIPC:  begin ALUsrcB = 1'b1; ALUsrcA = 2'b01; end
        OP_BRANCH: ALUop = 2'b01;
        default:   ;
      endcase
    end

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = DECODE;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          state_n     = HALT;
        end
      end
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_OP, OP_LUI,
          OP_BRANCH, OP_JALR, OP_JAL: state_n = EXEC;
          OP_SYSTEM: state_n = HALT;
          default: begin
            set_illegal = 1'b1;
            state_n     = HALT;
          end
        endcase
      end
      EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_n = MEM;
          OP_OP, OP_IMM, OP_LUI, OP_AUIPC: state_n = WB;
          OP_BRANCH: begin
            pc_src   = 2'b01;
            pc_write = branch_taken;
            state_n  = FETCH;
          end
          OP_JAL: begin
            pc_src   = 2'b01;
            pc_write = 1'b1;
            regWrite = 1'b1;
            wb_sel   = 2'b10;
            state_n  = FETCH;
          end
          OP_JALR: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            regWrite = 1'b1;
            wb_sel   = 2'b10;
            state_n  = FETCH;
          end
          default: state_n = HALT;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        mem_we  = (op_q == OP_STORE);
        if (mem_ready) begin
          state_n = (op_q == OP_LOAD) ? WB : FETCH;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          state_n     = HALT;
        end
      end
      WB: begin
        regWrite = 1'b1;
        wb_sel   = (op_q == OP_LOAD) ? 2'b01 : 2'b00;
        state_n  = FETCH;
      end
      HALT: begin
        halted  = 1'b1;
        illegal = illegal_q;
        bus_err = bus_err_q;
      end
      default: state_n = FETCH;
    endcase

    // Reset is synchronous, so the state may still be stale; mask everything while it is held
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      IorD     = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src   = 2'b00;
      ALUop    = 2'b00;
      ALUsrcA  = 2'b00;
      ALUsrcB  = 1'b0;
      regWrite = 1'b0;
      wb_sel   = 2'b00;
      halted   = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
    end
  end

  always_comb begin
    cnt_n = cnt;
    if (mem_ready || state_n != state) begin
      cnt_n = 8'd0;
    end else if (req) begin
      cnt_n = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      op_q      <= 5'd0;
      cnt       <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == DECODE) op_q <= opcode;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: steps one cycle at a time and compares the full
// output vector against hand-computed values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] opcode = 5'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, IorD, ir_write, pc_write;
  logic [1:0] pc_src, ALUop, ALUsrcA, wb_sel;
  logic       ALUsrcB, regWrite, halted, illegal, bus_err;
  logic [17:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .ALUop(ALUop),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .regWrite(regWrite), .wb_sel(wb_sel),
    .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, IorD, ir_write, pc_write, pc_src, ALUop, ALUsrcA,
                 ALUsrcB, regWrite, wb_sel, halted, illegal, bus_err};

  function automatic logic [17:0] v(input logic mreq, mwe, iord, irw, pcw,
                                    input logic [1:0] pcs, aop, asa,
                                    input logic asb, rw, input logic [1:0] wbs,
                                    input logic h, il, be);
    return {mreq, mwe, iord, irw, pcw, pcs, aop, asa, asb, rw, wbs, h, il, be};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then check the outputs of that cycle
  task automatic cyc(input string tag, input logic r, rdy, bt, input logic [4:0] opc,
                     input logic [17:0] exp);
    @(negedge clk);
    rst = r;
    mem_ready = rdy;
    branch_taken = bt;
    opcode = opc;
    #1;
    chk(tag, 32'(outs), 32'(exp));
  endtask

  logic [17:0] z, f_rdy, f_wait;

  initial begin
    z      = '0;
    f_rdy  = v(1,0,0,1,1,2'd0,2'd0,2'd0,0,0,2'd0,0,0,0);
    f_wait = v(1,0,0,0,0,2'd0,2'd0,2'd0,0,0,2'd0,0,0,0);

    cyc("rst0", 1, 1, 0, 5'd0, z);
    cyc("rst1", 1, 1, 0, 5'd0, z);

    // ADDI, zero-wait memory
    cyc("addi_fetch", 0, 1, 0, 5'd4, f_rdy);
    cyc("addi_dec",   0, 1, 0, 5'd4, z);
    cyc("addi_exec",  0, 1, 0, 5'd4, v(0,0,0,0,0,2'd0,2'd3,2'd0,1,0,2'd0,0,0,0));
    cyc("addi_wb",    0, 1, 0, 5'd4, v(0,0,0,0,0,2'd0,2'd3,2'd0,1,1,2'd0,0,0,0));

    // LW with three wait cycles in MEM
    cyc("lw_fetch", 0, 1, 0, 5'd0, f_rdy);
    cyc("lw_dec",   0, 1, 0, 5'd0, z);
    cyc("lw_exec",  0, 1, 0, 5'd0, v(0,0,0,0,0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0));
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_wait", 0, 0, 0, 5'd0, v(1,0,1,0,0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0));
    cyc("lw_mem_rdy", 0, 1, 0, 5'd0, v(1,0,1,0,0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0));
    cyc("lw_wb",      0, 1, 0, 5'd0, v(0,0,0,0,0,2'd0,2'd0,2'd0,1,1,2'd1,0,0,0));

    // SW
    cyc("sw_fetch", 0, 1, 0, 5'd8, f_rdy);
    cyc("sw_dec",   0, 1, 0, 5'd8, z);
    cyc("sw_exec",  0, 1, 0, 5'd8, v(0,0,0,0,0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0));
    cyc("sw_mem",   0, 1, 0, 5'd8, v(1,1,1,0,0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0));

    // BEQ not taken, then taken
    cyc("beq0_fetch", 0, 1, 0, 5'd24, f_rdy);
    cyc("beq0_dec",   0, 1, 0, 5'd24, z);
    cyc("beq0_exec",  0, 1, 0, 5'd24, v(0,0,0,0,0,2'd1,2'd1,2'd0,0,0,2'd0,0,0,0));
    cyc("beq1_fetch", 0, 1, 1, 5'd24, f_rdy);
    cyc("beq1_dec",   0, 1, 1, 5'd24, z);
    cyc("beq1_exec",  0, 1, 1, 5'd24, v(0,0,0,0,1,2'd1,2'd1,2'd0,0,0,2'd0,0,0,0));

    // JALR then JAL
    cyc("jalr_fetch", 0, 1, 0, 5'd25, f_rdy);
    cyc("jalr_dec",   0, 1, 0, 5'd25, z);
    cyc("jalr_exec",  0, 1, 0, 5'd25, v(0,0,0,0,1,2'd2,2'd0,2'd0,1,1,2'd2,0,0,0));
    cyc("jal_fetch",  0, 1, 0, 5'd27, f_rdy);
    cyc("jal_dec",    0, 1, 0, 5'd27, z);
    cyc("jal_exec",   0, 1, 0, 5'd27, v(0,0,0,0,1,2'd1,2'd0,2'd0,0,1,2'd2,0,0,0));

    // LUI
    cyc("lui_fetch", 0, 1, 0, 5'd13, f_rdy);
    cyc("lui_dec",   0, 1, 0, 5'd13, z);
    cyc("lui_exec",  0, 1, 0, 5'd13, v(0,0,0,0,0,2'd0,2'd0,2'd2,1,0,2'd0,0,0,0));
    cyc("lui_wb",    0, 1, 0, 5'd13, v(0,0,0,0,0,2'd0,2'd0,2'd2,1,1,2'd0,0,0,0));

    // Illegal opcode halts with cause; outputs frozen until reset
    cyc("ill_fetch", 0, 1, 0, 5'd31, f_rdy);
    cyc("ill_dec",   0, 1, 0, 5'd31, z);
    for (int i = 0; i < 3; i++)
      cyc("ill_halt", 0, 1, 1, 5'd31, v(0,0,0,0,0,2'd0,2'd0,2'd0,0,0,2'd0,1,1,0));
    cyc("ill_rst",   1, 1, 0, 5'd0, z);
    cyc("post_ill",  0, 0, 0, 5'd0, f_wait);
    cyc("post_ill2", 0, 1, 0, 5'd28, f_rdy);

    // SYSTEM halts without illegal
    cyc("sys_dec",  0, 1, 0, 5'd28, z);
    cyc("sys_halt", 0, 1, 0, 5'd28, v(0,0,0,0,0,2'd0,2'd0,2'd0,0,0,2'd0,1,0,0));
    cyc("sys_halt2",0, 1, 0, 5'd4,  v(0,0,0,0,0,2'd0,2'd0,2'd0,0,0,2'd0,1,0,0));
    cyc("sys_rst",  1, 0, 0, 5'd0, z);

    // Fetch timeout after four unanswered cycles
    for (int i = 0; i < 4; i++)
      cyc("to_fetch", 0, 0, 0, 5'd0, f_wait);
    cyc("to_halt",  0, 0, 0, 5'd0, v(0,0,0,0,0,2'd0,2'd0,2'd0,0,0,2'd0,1,0,1));
    cyc("to_halt2", 0, 1, 0, 5'd0, v(0,0,0,0,0,2'd0,2'd0,2'd0,0,0,2'd0,1,0,1));
    cyc("to_rst",   1, 0, 0, 5'd0, z);

    // Reset in the middle of a load access
    cyc("mr_fetch", 0, 1, 0, 5'd0, f_rdy);
    cyc("mr_dec",   0, 1, 0, 5'd0, z);
    cyc("mr_exec",  0, 1, 0, 5'd0, v(0,0,0,0,0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0));
    cyc("mr_mem",   0, 0, 0, 5'd0, v(1,0,1,0,0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0));
    cyc("mr_rst",   1, 0, 0, 5'd0, z);
    cyc("mr_after", 0, 0, 0, 5'd0, f_wait);
    cyc("mr_after2",0, 1, 0, 5'd4, f_rdy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
